// File: rtl/alu_exec_unit.sv
// ALU execution unit: add/sub/logic/compare/branch ops plus an iterative 1-bit-per-cycle shifter.
// Latency: 1 cycle for non-shift ops and zero-length shifts, N+1 cycles for an N-bit shift.
// Backpressure: the result is held until out_ready; a new request is accepted in the consume cycle.
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctl,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [4:0]        shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              branch_taken,
    output logic              zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_br;
    logic [4:0]        r_cnt;
    logic              r_dir_right;

    logic              w_accept;
    logic              w_is_shift;
    logic              w_start_shift;
    logic              w_shift_last;
    logic [DATA_W-1:0] w_shift_next;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_br;
    logic [DATA_W-1:0] w_diff;
    logic              w_lt_s;
    logic              w_lt_u;

    assign w_accept      = in_valid && in_ready;
    assign w_is_shift    = (alu_ctl == 4'd6) || (alu_ctl == 4'd7);
    assign w_start_shift = w_accept && w_is_shift && (shamt != 5'd0);
    assign w_shift_last  = (r_cnt == 5'd1);
    assign w_shift_next  = r_dir_right ? (r_result >> 1) : (r_result << 1);

    assign w_diff = op_a - op_b;
    assign w_lt_s = $signed(op_a) < $signed(op_b);
    assign w_lt_u = op_a < op_b;

    // Single-cycle ALU result and branch decision; shifts only reach here with shamt=0, so they pass op_b
    always_comb begin
        w_alu_res = '0;
        w_br      = 1'b0;
        case (alu_ctl)
            4'd0:  w_alu_res = op_a + op_b;
            4'd1:  w_alu_res = w_diff;
            4'd2:  w_alu_res = op_a & op_b;
            4'd3:  w_alu_res = op_a | op_b;
            4'd4:  w_alu_res = op_a ^ op_b;
            4'd5:  w_alu_res = ~(op_a | op_b);
            4'd6:  w_alu_res = op_b;
            4'd7:  w_alu_res = op_b;
            4'd8:  begin w_alu_res = w_diff; w_br = (op_a == op_b); end
            4'd9:  begin w_alu_res = w_diff; w_br = (op_a != op_b); end
            4'd10: begin w_alu_res = w_diff; w_br = !w_lt_s; end
            4'd11: begin w_alu_res = w_diff; w_br = !w_lt_s && (op_a != op_b); end
            4'd12: begin w_alu_res = w_diff; w_br = w_lt_s || (op_a == op_b); end
            4'd13: begin w_alu_res = w_diff; w_br = w_lt_s; end
            4'd14: w_alu_res = {{(DATA_W-1){1'b0}}, w_lt_s};
            4'd15: w_alu_res = {{(DATA_W-1){1'b0}}, w_lt_u};
            default: w_alu_res = '0;
        endcase
    end

    // Next-state and handshake outputs; a consume in HOLD may take a new request as if from IDLE
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = !rst;
                if (w_accept) w_state_nxt = w_start_shift ? ST_SHIFT : ST_HOLD;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_shift_last) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = !rst && out_ready;
                if (out_ready) begin
                    if (w_accept) w_state_nxt = w_start_shift ? ST_SHIFT : ST_HOLD;
                    else          w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Result datapath: load on acceptance, then shift one bit per cycle while iterating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_br        <= 1'b0;
            r_cnt       <= 5'd0;
            r_dir_right <= 1'b0;
        end else if (w_accept) begin
            if (w_start_shift) begin
                r_result    <= op_b;
                r_cnt       <= shamt;
                r_dir_right <= alu_ctl[0];
                r_zero      <= 1'b0;
                r_br        <= 1'b0;
            end else begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                r_br     <= w_br;
            end
        end else if (r_state == ST_SHIFT) begin
            r_result <= w_shift_next;
            r_cnt    <= r_cnt - 5'd1;
            if (w_shift_last) r_zero <= (w_shift_next == '0);
        end
    end

    assign result       = r_result;
    assign zero         = r_zero;
    assign branch_taken = r_br;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: table of ops with expected result/branch/latency,
// plus hand sequences for hold stability, back-to-back transfer and reset during shift/hold.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch_taken;
    logic        zero;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        br;
        int          lat;
    } vec_t;

    vec_t vq[$];

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_ctl      (alu_ctl),
        .op_a         (op_a),
        .op_b         (op_b),
        .shamt        (shamt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .zero         (zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s);
        alu_ctl = c;
        op_a    = a;
        op_b    = b;
        shamt   = s;
    endtask

    // Present one op with out_ready=1 from IDLE, measure latency, check outputs, then consume
    task automatic run_op(input vec_t v, input int idx);
        int lat;
        int busy_cnt;
        int rdy_seen;
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v.ctl, v.a, v.b, v.sh);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9);
        lat      = 1;
        busy_cnt = 0;
        rdy_seen = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_seen++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_busy_cycles"}, busy_cnt, v.lat - 1);
        if (v.lat > 1) chk({tag, "_ready_in_shift"}, rdy_seen, 0);
        chk({tag, "_result"}, result, v.res);
        chk({tag, "_zero"}, zero, (v.res == 32'd0));
        chk({tag, "_branch"}, branch_taken, v.br);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 5'd0);

        //          ctl    a             b             sh     result        br   lat
        vq.push_back('{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1});
        vq.push_back('{4'd1,  32'h0000_0005, 32'h0000_0007, 5'd0,  32'hFFFF_FFFE, 1'b0, 1});
        vq.push_back('{4'd1,  32'h0000_0003, 32'h0000_0003, 5'd0,  32'h0000_0000, 1'b0, 1});
        vq.push_back('{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1});
        vq.push_back('{4'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0,  32'hFFFF_F0F0, 1'b0, 1});
        vq.push_back('{4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 5'd0,  32'h5555_5555, 1'b0, 1});
        vq.push_back('{4'd5,  32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 1});
        vq.push_back('{4'd8,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1});
        vq.push_back('{4'd9,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1});
        vq.push_back('{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'hFFFF_FFFE, 1'b0, 1});
        vq.push_back('{4'd11, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0002, 1'b1, 1});
        vq.push_back('{4'd12, 32'h0000_0003, 32'h0000_0003, 5'd0,  32'h0000_0000, 1'b1, 1});
        vq.push_back('{4'd13, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'hFFFF_FFFE, 1'b1, 1});
        vq.push_back('{4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'hFFFF_FFFE, 1'b0, 1});
        vq.push_back('{4'd15, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1});
        vq.push_back('{4'd14, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1});
        vq.push_back('{4'd7,  32'h0000_0000, 32'h0000_00A5, 5'd0,  32'h0000_00A5, 1'b0, 1});
        vq.push_back('{4'd6,  32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 32});
        vq.push_back('{4'd7,  32'h0000_0000, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 5});
        vq.push_back('{4'd6,  32'h0000_0000, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 32});
        vq.push_back('{4'd7,  32'h0000_0000, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b0, 2});
        vq.push_back('{4'd6,  32'h0000_FFFF, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 5});

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_branch", branch_taken, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vq[i]) run_op(vq[i], i);

        // beq held for 3 cycles under backpressure, then consume + accept with no bubble
        drive(4'd8, 32'd5, 32'd5, 5'd0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(4'd0, 32'hFFFF_FFFF, 32'h0000_0010, 5'd3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", c), out_valid, 1);
            chk($sformatf("hold%0d_result", c), result, 0);
            chk($sformatf("hold%0d_zero", c), zero, 1);
            chk($sformatf("hold%0d_branch", c), branch_taken, 1);
            chk($sformatf("hold%0d_in_ready", c), in_ready, 0);
            @(posedge clk); #1;
        end
        drive(4'd0, 32'd2, 32'd3, 5'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_result", result, 5);
        chk("b2b_zero", zero, 0);
        chk("b2b_branch", branch_taken, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_idle_valid", out_valid, 0);
        @(posedge clk); #1;

        // Requests offered during SHIFT are ignored; result stays that of the shift
        drive(4'd6, 32'd0, 32'd1, 5'd3);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        drive(4'd0, 32'd7, 32'd7, 5'd0);
        seen = 0;
        @(negedge clk);
        while (!out_valid && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        chk("ignore_shift_lat", seen, 3);
        chk("ignore_shift_result", result, 8);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a 20-bit srl discards it
        drive(4'd7, 32'd0, 32'hFFFF_FFFF, 5'd20);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("midshift_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midshift_busy", busy, 0);
        chk("midshift_valid", out_valid, 0);
        chk("midshift_result", result, 0);
        chk("midshift_in_ready", in_ready, 1);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        chk("midshift_no_output", seen, 0);
        @(posedge clk); #1;

        // Reset while holding a result drops it; in_ready low while rst is high
        drive(4'd0, 32'd1, 32'd1, 5'd0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("holdrst_valid_before", out_valid, 1);
        chk("holdrst_result_before", result, 2);
        @(posedge clk); #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("holdrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("holdrst_valid", out_valid, 0);
        chk("holdrst_result", result, 0);
        chk("holdrst_zero", zero, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning operand and result width.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1, meaning a request is presented.
REQ-005 The module SHALL have port in_ready, output, 1, meaning a request is accepted this cycle.
REQ-006 The module SHALL have port alu_ctl, input, 4, the ALU control code.
REQ-007 The module SHALL have ports op_a and op_b, input, DATA_W, the operands.
REQ-008 The module SHALL have port shamt, input, 5, the shift amount.
REQ-009 The module SHALL have port out_valid, output, 1, meaning the result is held.
REQ-010 The module SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The module SHALL have port result, output, DATA_W, the result data.
REQ-012 The module SHALL have port branch_taken, output, 1, the compare outcome.
REQ-013 The module SHALL have port zero, output, 1, set when result equals 0.
REQ-014 The module SHALL have port busy, output, 1, set while a shift iterates.

Function
REQ-015 alu_ctl SHALL map as follows: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 sll, 7 srl, 8 beq, 9 bneq, 10 bge, 11 bgt, 12 ble, 13 blt, 14 slt (signed), 15 sltu.
REQ-016 Arithmetic SHALL wrap modulo 2^DATA_W, with no overflow flag.
REQ-017 slt/sltu SHALL produce result 1 or 0.
REQ-018 For codes 8-13, result SHALL be op_a-op_b and branch_taken SHALL be the signed compare of op_a vs op_b.
REQ-019 branch_taken SHALL be 0 for all codes other than 8-13.
REQ-020 sll/srl SHALL shift op_b by shamt, logically, with zero fill.
REQ-021 The FSM SHALL have three states: IDLE, SHIFT and HOLD.
REQ-022 A transfer SHALL occur on in_valid && in_ready.
REQ-023 in_ready SHALL be 1 only in IDLE, or in HOLD with out_ready=1 in the same cycle.
REQ-024 Non-shift ops, and shifts with shamt=0, SHALL register the result at acceptance and go to HOLD, giving out_valid=1 the next cycle (latency 1).
REQ-025 A shift with shamt=N>0 SHALL load op_b and go to SHIFT, shifting 1 bit per cycle for N cycles, then go to HOLD (latency N+1 cycles from acceptance to out_valid).
REQ-026 busy SHALL be 1 exactly in SHIFT, and in_ready SHALL be 0 in SHIFT.
REQ-027 In HOLD, result, zero and branch_taken SHALL be held stable until out_ready=1.
REQ-028 out_ready=1 in HOLD with no new transfer SHALL go to IDLE with out_valid=0.
REQ-029 Simultaneous consume and accept in HOLD SHALL be back-to-back: the new request is processed exactly as from IDLE, with no bubble for single-cycle ops.
REQ-030 zero SHALL be computed from the final registered result.
REQ-031 out_ready SHALL be ignored outside HOLD.
REQ-032 Inputs SHALL be ignored when no transfer occurs.

Reset
REQ-033 rst=1 SHALL force IDLE, out_valid=0, result=0, zero=0, branch_taken=0, busy=0 next edge.
REQ-034 rst SHALL take priority over all events, including mid-SHIFT and in HOLD; the in-flight operation SHALL be discarded with no output.
REQ-035 in_ready SHALL be 0 while rst=1.

Verification
REQ-036 Scenario: add 0x7FFFFFFF+1, out_ready=1 -> next cycle out_valid=1, result=0x80000000, zero=0, branch_taken=0.
REQ-037 Scenario: sll, op_b=0x1, shamt=31 -> busy for 31 cycles, in_ready=0 throughout, then result=0x80000000 at cycle 32.
REQ-038 Scenario: blt op_a=0xFFFFFFFF, op_b=1 -> branch_taken=1; bgt same operands -> 0; sltu same operands -> result=0.
REQ-039 Scenario: beq 5,5 with out_ready=0 for 3 cycles -> result=0, zero=1, branch_taken=1 held stable; consume with a new request in the same cycle -> no bubble.
REQ-040 Scenario: rst asserted during srl with shamt=20 at cycle 5 -> next cycle IDLE, busy=0, out_valid=0, and no result emitted.
REQ-041 Scenario: srl with shamt=0, op_b=0xA5 -> latency 1, result=0xA5.
